// File: rtl/mcb_ini_pkg.sv
// Shared definitions for the MCB init sequencer: command opcodes, FSM state encoding,
// and the timer-width helper.
package mcb_ini_pkg;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_PREA = 3'd1;
   localparam logic [2:0] OP_REF  = 3'd2;
   localparam logic [2:0] OP_LMR  = 3'd3;

   localparam int A10_IDX = 10;

   typedef enum logic [3:0] {
      ST_WAIT  = 4'd0,
      ST_PREA  = 4'd1,
      ST_TRP   = 4'd2,
      ST_REF   = 4'd3,
      ST_TRFC  = 4'd4,
      ST_LMR   = 4'd5,
      ST_TMRD  = 4'd6,
      ST_EMR   = 4'd7,
      ST_TEMR  = 4'd8,
      ST_READY = 4'd9
   } ini_state_t;

   // The timer never holds more than (largest delay - 1), so clog2 of the largest delay suffices.
   function automatic int tmr_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/mcb_ini_timer.sv
// Loadable down-counter with a zero flag; it stops at zero instead of wrapping.
module mcb_ini_timer
   import mcb_ini_pkg::*;
#(
   parameter int           W       = 4,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   // Load takes priority over decrement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= RST_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end else begin
         count <= count;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mcb_ini_seq.sv
// SDR SDRAM power-up initialisation sequencer: PREA, N_REF x REF, LMR and an optional EMR,
// per rank, then READY. All outputs are a registered decode of the next state.
module mcb_ini_seq
   import mcb_ini_pkg::*;
#(
   parameter int            N_CS    = 2,
   parameter int            CSW     = 1,
   parameter int            T_INIT  = 20000,
   parameter int            T_RP    = 3,
   parameter int            T_RFC   = 7,
   parameter int            T_MRD   = 2,
   parameter int            N_REF   = 8,
   parameter int            EMR_EN  = 0,
   parameter int            AW      = 13,
   parameter int            BAW     = 2,
   parameter logic [AW-1:0] MR_VAL  = 13'h032,
   parameter logic [AW-1:0] EMR_VAL = 13'h000
) (
   input  logic            mcb_clk,
   input  logic            mcb_rst,
   input  logic            mcb_sclr_n,
   input  logic            reinit_req,
   output logic            cmd_valid,
   input  logic            cmd_ack,
   output logic [2:0]      cmd_op,
   output logic [N_CS-1:0] cmd_cs,
   output logic [BAW-1:0]  cmd_ba,
   output logic [AW-1:0]   cmd_addr,
   output logic [CSW-1:0]  ini_rank,
   output logic            ini_busy,
   output logic            ini_ready
);

   localparam int TW = tmr_width(T_INIT, T_RFC, T_RP, T_MRD);
   localparam int RW = (N_REF > 1) ? $clog2(N_REF) : 1;

   // Wait states are entered with T_x-2 so the next command appears T_x cycles after the ack.
   localparam logic [TW-1:0]  INIT_LD   = TW'(T_INIT - 1);
   localparam logic [TW-1:0]  RP_LD     = TW'((T_RP  > 1) ? T_RP  - 2 : 0);
   localparam logic [TW-1:0]  RFC_LD    = TW'((T_RFC > 1) ? T_RFC - 2 : 0);
   localparam logic [TW-1:0]  MRD_LD    = TW'((T_MRD > 1) ? T_MRD - 2 : 0);
   localparam logic [RW-1:0]  REF_LAST  = RW'(N_REF - 1);
   localparam logic [CSW-1:0] RANK_LAST = CSW'(N_CS - 1);
   localparam logic [AW-1:0]  PREA_ADDR = AW'(1) << A10_IDX;
   localparam logic [BAW-1:0] EMR_BA    = BAW'(2);

   ini_state_t      state, nxt;
   ini_state_t      ref_state, step_state, mrd_state;
   logic [RW-1:0]   ref_cnt, nref, ref_next;
   logic [CSW-1:0]  rank, nrank, step_rank, mrd_rank;
   logic            tmr_ld, tmr_dec, tmr_zero;
   logic [TW-1:0]   tmr_val;
   logic            d_valid;
   logic [2:0]      d_op;
   logic [BAW-1:0]  d_ba;
   logic [AW-1:0]   d_addr;
   logic [N_CS-1:0] d_cs;

   assign ref_state  = (ref_cnt == REF_LAST) ? ST_LMR : ST_REF;
   assign ref_next   = (ref_cnt == REF_LAST) ? '0 : ref_cnt + RW'(1);
   assign step_state = (rank == RANK_LAST) ? ST_READY : ST_PREA;
   assign step_rank  = (rank == RANK_LAST) ? rank : rank + CSW'(1);
   assign mrd_state  = (EMR_EN != 0) ? ST_EMR : step_state;
   assign mrd_rank   = (EMR_EN != 0) ? rank : step_rank;

   mcb_ini_timer #(.W(TW), .RST_VAL(INIT_LD)) u_timer (
      .clk      (mcb_clk),
      .rst      (mcb_rst),
      .load     (tmr_ld),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Next-state, counter and timer-control logic; a synchronous clear overrides everything.
   always_comb begin
      nxt     = state;
      nrank   = rank;
      nref    = ref_cnt;
      tmr_ld  = 1'b0;
      tmr_val = '0;
      tmr_dec = 1'b0;
      if (!mcb_sclr_n) begin
         nxt     = ST_WAIT;
         nrank   = '0;
         nref    = '0;
         tmr_ld  = 1'b1;
         tmr_val = INIT_LD;
      end else begin
         case (state)
            ST_WAIT:  if (tmr_zero) nxt = ST_PREA; else tmr_dec = 1'b1;
            ST_PREA: begin
               if (cmd_ack) begin
                  if (T_RP > 1) begin
                     nxt = ST_TRP; tmr_ld = 1'b1; tmr_val = RP_LD;
                  end else begin
                     nxt = ST_REF;
                  end
               end else begin
                  nxt = ST_PREA;
               end
            end
            ST_TRP:   if (tmr_zero) nxt = ST_REF; else tmr_dec = 1'b1;
            ST_REF: begin
               if (cmd_ack) begin
                  if (T_RFC > 1) begin
                     nxt = ST_TRFC; tmr_ld = 1'b1; tmr_val = RFC_LD;
                  end else begin
                     nxt = ref_state; nref = ref_next;
                  end
               end else begin
                  nxt = ST_REF;
               end
            end
            ST_TRFC: begin
               if (tmr_zero) begin
                  nxt = ref_state; nref = ref_next;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            ST_LMR: begin
               if (cmd_ack) begin
                  if (T_MRD > 1) begin
                     nxt = ST_TMRD; tmr_ld = 1'b1; tmr_val = MRD_LD;
                  end else begin
                     nxt = mrd_state; nrank = mrd_rank;
                  end
               end else begin
                  nxt = ST_LMR;
               end
            end
            ST_TMRD: begin
               if (tmr_zero) begin
                  nxt = mrd_state; nrank = mrd_rank;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            ST_EMR: begin
               if (cmd_ack) begin
                  if (T_MRD > 1) begin
                     nxt = ST_TEMR; tmr_ld = 1'b1; tmr_val = MRD_LD;
                  end else begin
                     nxt = step_state; nrank = step_rank;
                  end
               end else begin
                  nxt = ST_EMR;
               end
            end
            ST_TEMR: begin
               if (tmr_zero) begin
                  nxt = step_state; nrank = step_rank;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            ST_READY: begin
               if (reinit_req) begin
                  nxt = ST_PREA; nrank = '0;
               end else begin
                  nxt = ST_READY;
               end
            end
            default:  nxt = ST_WAIT;
         endcase
      end
   end

   // Command payload decoded from the next state so it lands in the output registers with it.
   always_comb begin
      d_valid = 1'b0;
      d_op    = OP_NOP;
      d_ba    = '0;
      d_addr  = '0;
      case (nxt)
         ST_PREA: begin d_valid = 1'b1; d_op = OP_PREA; d_addr = PREA_ADDR; end
         ST_REF:  begin d_valid = 1'b1; d_op = OP_REF; end
         ST_LMR:  begin d_valid = 1'b1; d_op = OP_LMR; d_addr = MR_VAL; end
         ST_EMR:  begin d_valid = 1'b1; d_op = OP_LMR; d_ba = EMR_BA; d_addr = EMR_VAL; end
         default: begin d_valid = 1'b0; d_op = OP_NOP; end
      endcase
      d_cs = d_valid ? (N_CS'(1) << nrank) : '0;
   end

   // State, counters and registered outputs.
   always_ff @(posedge mcb_clk or posedge mcb_rst) begin
      if (mcb_rst) begin
         state     <= ST_WAIT;
         ref_cnt   <= '0;
         rank      <= '0;
         cmd_valid <= 1'b0;
         cmd_op    <= OP_NOP;
         cmd_cs    <= '0;
         cmd_ba    <= '0;
         cmd_addr  <= '0;
         ini_rank  <= '0;
         ini_busy  <= 1'b0;
         ini_ready <= 1'b0;
      end else begin
         state     <= nxt;
         ref_cnt   <= nref;
         rank      <= nrank;
         cmd_valid <= d_valid;
         cmd_op    <= d_op;
         cmd_cs    <= d_cs;
         cmd_ba    <= d_ba;
         cmd_addr  <= d_addr;
         ini_rank  <= nrank;
         ini_busy  <= (nxt != ST_WAIT) && (nxt != ST_READY);
         ini_ready <= (nxt == ST_READY);
      end
   end

endmodule

// File: tb/tb_mcb_ini_seq.sv
// Self-checking bench: expected command tables built from the timing rules, checked per command,
// plus hand sequences for ack hold-off, reinit, reset and synchronous clear.
module tb_mcb_ini_seq;
   import mcb_ini_pkg::*;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  cs;
      logic [1:0]  ba;
      logic [12:0] addr;
      int          cyc;
   } exp_t;

   localparam logic [12:0] MR_EXP   = 13'h032;
   localparam logic [12:0] EMR_EXP  = 13'h0A5;
   localparam logic [12:0] PREA_EXP = 13'h400;

   exp_t tab [0:63];
   int   n_tab;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   logic clk = 1'b0;
   logic rst_a, rst_b, sclr_n, reinit_a, ack, use_b;

   logic        a_valid, a_busy, a_ready;
   logic [2:0]  a_op;
   logic [1:0]  a_cs, a_ba;
   logic [12:0] a_addr;
   logic [0:0]  a_rank;
   logic        b_valid, b_busy, b_ready;
   logic [2:0]  b_op;
   logic [0:0]  b_cs;
   logic [1:0]  b_ba;
   logic [12:0] b_addr;
   logic [0:0]  b_rank;

   logic        m_valid, m_busy, m_ready;
   logic [2:0]  m_op;
   logic [1:0]  m_cs, m_ba;
   logic [12:0] m_addr;

   always #5 clk = ~clk;

   mcb_ini_seq #(.T_INIT(10)) dut_a (
      .mcb_clk(clk), .mcb_rst(rst_a), .mcb_sclr_n(sclr_n), .reinit_req(reinit_a),
      .cmd_valid(a_valid), .cmd_ack(ack), .cmd_op(a_op), .cmd_cs(a_cs), .cmd_ba(a_ba),
      .cmd_addr(a_addr), .ini_rank(a_rank), .ini_busy(a_busy), .ini_ready(a_ready)
   );

   mcb_ini_seq #(.N_CS(1), .CSW(1), .T_INIT(4), .T_RP(1), .T_RFC(2), .T_MRD(1), .N_REF(2),
                 .EMR_EN(1), .EMR_VAL(13'h0A5)) dut_b (
      .mcb_clk(clk), .mcb_rst(rst_b), .mcb_sclr_n(1'b1), .reinit_req(1'b0),
      .cmd_valid(b_valid), .cmd_ack(ack), .cmd_op(b_op), .cmd_cs(b_cs), .cmd_ba(b_ba),
      .cmd_addr(b_addr), .ini_rank(b_rank), .ini_busy(b_busy), .ini_ready(b_ready)
   );

   always_comb begin
      if (use_b) begin
         m_valid = b_valid; m_op = b_op; m_cs = {1'b0, b_cs}; m_ba = b_ba;
         m_addr = b_addr; m_busy = b_busy; m_ready = b_ready;
      end else begin
         m_valid = a_valid; m_op = a_op; m_cs = a_cs; m_ba = a_ba;
         m_addr = a_addr; m_busy = a_busy; m_ready = a_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] op, input logic [1:0] cs, input logic [1:0] ba,
                      input logic [12:0] addr, input int t);
      tab[n_tab].op   = op;
      tab[n_tab].cs   = cs;
      tab[n_tab].ba   = ba;
      tab[n_tab].addr = addr;
      tab[n_tab].cyc  = t;
      n_tab++;
   endtask

   // Expected first-valid cycle of every command; a held entry delays everything after it by 5.
   task automatic build(input int base, input int nranks, input int nref, input int trp,
                        input int trfc, input int tmrd, input int emr, input int hold,
                        output int rdy);
      int t;
      t = base;
      n_tab = 0;
      for (int r = 0; r < nranks; r++) begin
         add(OP_PREA, (r == 0) ? 2'b01 : 2'b10, 2'b00, PREA_EXP, t);
         t += trp + ((n_tab - 1 == hold) ? 5 : 0);
         for (int i = 0; i < nref; i++) begin
            add(OP_REF, (r == 0) ? 2'b01 : 2'b10, 2'b00, 13'h000, t);
            t += trfc + ((n_tab - 1 == hold) ? 5 : 0);
         end
         add(OP_LMR, (r == 0) ? 2'b01 : 2'b10, 2'b00, MR_EXP, t);
         t += tmrd;
         if (emr != 0) begin
            add(OP_LMR, (r == 0) ? 2'b01 : 2'b10, 2'b10, EMR_EXP, t);
            t += tmrd;
         end
      end
      rdy = t;
   endtask

   task automatic run_cmds(input int n, input int hold, input int reinit_at);
      for (int k = 0; k < n; k++) begin
         int b;
         b = 0;
         while (!m_valid && b < 300) begin
            tick();
            b++;
         end
         if (!m_valid) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: command %0d never valid, expected at cycle %0d", k, tab[k].cyc);
            return;
         end
         chk("cmd_cycle", cyc,   tab[k].cyc);
         chk("cmd_op",    m_op,  tab[k].op);
         chk("cmd_cs",    m_cs,  tab[k].cs);
         chk("cmd_ba",    m_ba,  tab[k].ba);
         chk("cmd_addr",  m_addr, tab[k].addr);
         chk("busy_in_seq",  m_busy,  1);
         chk("ready_in_seq", m_ready, 0);
         if (k == hold) begin
            ack = 1'b0;
            repeat (5) begin
               tick();
               chk("hold_valid", m_valid, 1);
               chk("hold_op",    m_op,    tab[k].op);
               chk("hold_cs",    m_cs,    tab[k].cs);
            end
            ack = 1'b1;
         end
         if (k == reinit_at) reinit_a = 1'b1;
         tick();
         reinit_a = 1'b0;
      end
   endtask

   task automatic wait_ready(input int rdy);
      int b;
      b = 0;
      while (!m_ready && b < 300) begin
         tick();
         b++;
      end
      chk("ready_cycle", cyc, rdy);
      chk("ready_flag",  m_ready, 1);
      chk("ready_busy",  m_busy,  0);
      chk("ready_valid", m_valid, 0);
   endtask

   initial begin
      int rdy;
      rst_a = 1'b1; rst_b = 1'b1; sclr_n = 1'b1; reinit_a = 1'b0; ack = 1'b1; use_b = 1'b0;
      #1;
      chk("rst_valid", a_valid, 0);
      chk("rst_busy",  a_busy,  0);
      chk("rst_ready", a_ready, 0);
      chk("rst_op",    a_op,    OP_NOP);
      chk("rst_cs",    a_cs,    0);
      repeat (3) tick();

      // Full two-rank power-up with T_INIT=10 and ack always high.
      rst_a = 1'b0;
      cyc = 0;
      build(10, 2, 8, 3, 7, 2, 0, -1, rdy);
      run_cmds(n_tab, -1, -1);
      wait_ready(rdy);

      // Reinit from READY; reinit during REF ignored; 3rd REF ack withheld 5 cycles.
      reinit_a = 1'b1;
      build(cyc + 1, 2, 8, 3, 7, 2, 0, 3, rdy);
      tick();
      reinit_a = 1'b0;
      run_cmds(13, 3, 1);
      chk("trfc_rank", a_rank, 1);
      chk("trfc_busy", a_busy, 1);

      // Asynchronous reset in rank 1 TRFC.
      rst_a = 1'b1;
      #1;
      chk("async_rst_busy",  a_busy,  0);
      chk("async_rst_rank",  a_rank,  0);
      chk("async_rst_valid", a_valid, 0);
      chk("async_rst_ready", a_ready, 0);
      tick();
      tick();
      rst_a = 1'b0;
      cyc = 0;
      build(10, 2, 8, 3, 7, 2, 0, -1, rdy);
      run_cmds(n_tab, -1, -1);
      wait_ready(rdy);

      // Synchronous clear with a simultaneous reinit request: clear wins, T_INIT wait again.
      sclr_n = 1'b0;
      reinit_a = 1'b1;
      tick();
      sclr_n = 1'b1;
      reinit_a = 1'b0;
      chk("sclr_ready", a_ready, 0);
      chk("sclr_busy",  a_busy,  0);
      chk("sclr_valid", a_valid, 0);
      build(cyc + 10, 2, 8, 3, 7, 2, 0, -1, rdy);
      run_cmds(1, -1, -1);

      // Single rank with EMR and unit spacings.
      use_b = 1'b1;
      rst_b = 1'b0;
      cyc = 0;
      build(4, 1, 2, 1, 2, 1, 1, -1, rdy);
      run_cmds(n_tab, -1, -1);
      wait_ready(rdy);
      chk("b_rank", b_rank, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
